// File: rtl/i2c_byte_engine.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Every SCL quarter lasts Q PCLK cycles; Q is chosen by the speed latched at accept.
module i2c_byte_engine #(
    parameter int QTR_STD  = 50,
    parameter int QTR_FAST = 12
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_start,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic       cmd_speed,
    input  logic [7:0] cmd_wdata,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
    } state_t;

    localparam logic [15:0] STD_LAST  = 16'(QTR_STD - 1);
    localparam logic [15:0] FAST_LAST = 16'(QTR_FAST - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        speed_q, speed_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  shift_q, shift_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic [15:0] q_last;
    logic        qend;
    logic [7:0]  tx_byte;
    logic [2:0]  nbit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        speed_d   = speed_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        scl_d     = scl_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rd_data_d = rd_data_q;

        q_last  = speed_q ? FAST_LAST : STD_LAST;
        qend    = (cnt_q == q_last);
        tx_byte = {addr_q, rw_q};
        nbit    = bit_q + 3'd1;

        if (state_q == IDLE) begin
            // done_q blocks a strobe arriving in the same cycle as the done pulse
            if (cmd_start && !done_q) begin
                addr_d    = cmd_addr;
                rw_d      = cmd_rw;
                speed_d   = cmd_speed;
                wdata_d   = cmd_wdata;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
                state_d   = START;
                cnt_d     = 16'd0;
                qtr_d     = 2'd0;
                scl_d     = 1'b1;
                sda_oe_d  = 1'b0;
            end
        end else begin
            cnt_d = qend ? 16'd0 : cnt_q + 16'd1;
            if (qend) begin
                qtr_d = qtr_q + 2'd1;
                case (state_q)
                    START: begin
                        if (qtr_q == 2'd0) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = ADDR;
                            qtr_d    = 2'd0;
                            bit_d    = 3'd0;
                            scl_d    = 1'b0;
                            sda_oe_d = ~tx_byte[7];
                        end
                    end
                    ADDR, ADDR_ACK, DATA, DATA_ACK: begin
                        if (qtr_q == 2'd1) begin
                            scl_d = 1'b1;
                        end
                        if (qtr_q == 2'd2) begin
                            case (state_q)
                                ADDR_ACK: if (sda_in) ack_err_d = 1'b1;
                                DATA:     shift_d = {shift_q[6:0], sda_in};
                                DATA_ACK: if (!rw_q && sda_in) ack_err_d = 1'b1;
                                default:  ;
                            endcase
                        end
                        // End of slot: SCL falls and SDA takes the next slot's value together
                        if (qtr_q == 2'd3) begin
                            scl_d = 1'b0;
                            case (state_q)
                                ADDR: begin
                                    if (bit_q == 3'd7) begin
                                        state_d  = ADDR_ACK;
                                        sda_oe_d = 1'b0;
                                    end else begin
                                        bit_d    = nbit;
                                        sda_oe_d = ~tx_byte[3'd7 - nbit];
                                    end
                                end
                                ADDR_ACK: begin
                                    if (ack_err_q) begin
                                        state_d  = STOP;
                                        sda_oe_d = 1'b1;
                                    end else begin
                                        state_d  = DATA;
                                        bit_d    = 3'd0;
                                        sda_oe_d = ~rw_q & ~wdata_q[7];
                                    end
                                end
                                DATA: begin
                                    if (bit_q == 3'd7) begin
                                        state_d  = DATA_ACK;
                                        sda_oe_d = 1'b0;
                                    end else begin
                                        bit_d    = nbit;
                                        sda_oe_d = ~rw_q & ~wdata_q[3'd7 - nbit];
                                    end
                                end
                                default: begin
                                    state_d  = STOP;
                                    sda_oe_d = 1'b1;
                                end
                            endcase
                        end
                    end
                    STOP: begin
                        if (qtr_q == 2'd0) begin
                            scl_d = 1'b1;
                        end else if (qtr_q == 2'd1) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            qtr_d   = 2'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            // on a read, ack_err can only come from the address phase
                            if (rw_q && !ack_err_q) begin
                                rd_data_d = shift_q;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            addr_q    <= 7'd0;
            rw_q      <= 1'b0;
            speed_q   <= 1'b0;
            wdata_q   <= 8'd0;
            shift_q   <= 8'd0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            speed_q   <= speed_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rd_data = rd_data_q;

endmodule

// File: doc/i2c_byte_engine.md
# i2c_byte_engine

Bit-level I2C master engine that sits directly downstream of the APB command register in `mod_top`. It consumes the decoded command fields (7-bit slave address, R/W, data byte, speed, start strobe) and runs one complete single-byte transfer on the bus: START, address+R/W, ACK, data byte, ACK/NACK, STOP. It reports busy, done, read data and an acknowledge error back to the register stage.

## Interface
- `QTR_STD`, default 50: PCLK cycles per SCL quarter-period when `cmd_speed`=0 (100 kHz at 20 MHz PCLK).
- `QTR_FAST`, default 12: PCLK cycles per SCL quarter-period when `cmd_speed`=1 (~400 kHz).
- `PCLK`  in  1  system clock; all logic is on the rising edge.
- `PRESET`  in  1  reset, asynchronous, active-high.
- `cmd_start`  in  1  one-cycle strobe requesting a transfer.
- `cmd_addr`  in  7  slave address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_speed`  in  1  0 = standard, 1 = fast.
- `cmd_wdata`  in  8  byte to write (ignored on read).
- `sda_in`  in  1  sampled SDA line level.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (open drain).
- `scl`  out  1  SCL level (push-pull, no clock stretching).
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer end.
- `ack_err`  out  1  slave NACK seen in the last transfer.
- `rd_data`  out  8  byte received by the last read.

## Operation
- Reset values: `scl`=1, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0, `rd_data`=0, state IDLE, quarter counter 0.
- Acceptance: `cmd_start`=1 in IDLE latches all `cmd_*` fields, clears `ack_err`, sets `busy` on the same edge. `cmd_start` while busy is ignored; the latched fields do not change.
- Q = QTR_FAST if the latched speed is 1, else QTR_STD. Each quarter lasts exactly Q cycles.
- States: IDLE -> START -> ADDR -> ADDR_ACK -> DATA -> DATA_ACK -> STOP -> IDLE. ADDR_ACK goes to STOP on a NACK.
- START, 2 quarters: q0 SCL=1, SDA released; q1 SCL=1, SDA low.
- Bit slot, 4 quarters: q0 and q1 SCL=0, q2 and q3 SCL=1. `sda_oe` changes only on entry to q0. `sda_in` is sampled on the last cycle of q2.
- ADDR: 8 slots, MSB first: addr[6:0], then rw. A 1 bit is released and a 0 bit is pulled low.
- ADDR_ACK: 1 slot with SDA released. A sampled 1 sets `ack_err` and goes to STOP without the data phase.
- DATA on write: 8 slots driving wdata MSB first. DATA_ACK releases SDA. A sampled 1 sets `ack_err`, and the engine still goes to STOP.
- DATA on read: 8 slots with SDA released, sampled bits shifted in MSB first. DATA_ACK: the master releases SDA (NACK) to end the read.
- STOP, 3 quarters: q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2 SCL=1, SDA released.
- End of transfer: `done`=1 for one cycle, `busy`=0 on the same edge, state returns to IDLE.
- `rd_data` updates on the `done` edge only after a read with no address NACK. Otherwise it holds its previous value.
- `ack_err` holds until the next accepted command or reset.

## Timing
- Full transfer: 2 + 18×4 + 3 = 77 quarters. `busy` is high for exactly 77·Q cycles after the accept edge. `done` is asserted in the cycle after the last STOP quarter.
- Address NACK: 2 + 9×4 + 3 = 41 quarters, i.e. 41·Q cycles.
- A new `cmd_start` in the same cycle as `done` is ignored. The earliest accept is the cycle after `done`.
- `PRESET` mid-transfer: outputs return to reset values immediately (asynchronous). SCL goes high and SDA is released with no STOP generated. The engine is in IDLE on the first edge after reset deasserts.
- Q is frozen at acceptance. A change on `cmd_speed` during a transfer has no effect.

## Test plan
- Write, ACKed (bench Q: QTR_STD=4). Stimulus: addr=0x60, rw=0, wdata=0xF5, speed=0; slave model ACKs both bytes. Required: SDA bit sequence 1100000_0, then 11110101; `done` exactly 308 cycles after accept; `ack_err`=0.
- Read (QTR_FAST=2). Stimulus: addr=0x60, rw=1, speed=1; slave returns 0xA3. Required: master releases SDA on the 9th data bit; `rd_data`=0xA3 at `done`; `busy` width 154 cycles.
- Address NACK. Stimulus: slave never pulls SDA low. Required: `ack_err`=1; no data slots; `done` at 41·Q cycles; `rd_data` unchanged.
- Busy rejection. Stimulus: second `cmd_start` with addr=0x11 issued 10 cycles after the first accept. Required: bus shows only addr 0x60; exactly one `done` pulse.
- Reset mid-transfer. Stimulus: assert `PRESET` during the ADDR bit 3 slot. Required: in the same cycle `scl`=1, `sda_oe`=0, `busy`=0; a new command afterwards completes normally.
- Protocol checker throughout all scenarios: SDA changes only while SCL=0, except the START and STOP edges; START/STOP ordering is correct.
